// File: rtl/vdb_vga_pkg.sv
// Shared types and default 640x480 timing for the VGA stream transmitter.
package vdb_vga_pkg;

   localparam int DEF_HOR_ACT    = 640;
   localparam int DEF_HOR_FP     = 16;
   localparam int DEF_HOR_SYNC   = 96;
   localparam int DEF_HOR_BP     = 48;
   localparam int DEF_VERT_ACT   = 480;
   localparam int DEF_VERT_FP    = 11;
   localparam int DEF_VERT_SYNC  = 2;
   localparam int DEF_VERT_BP    = 31;
   localparam int DEF_FIFO_DEPTH = 16;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // One FIFO entry: the start-of-frame marker travels with its pixel.
   typedef struct packed {
      logic sof;
      rgb_t rgb;
   } fifo_word_t;

   localparam int FIFO_WIDTH = $bits(fifo_word_t);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HUNT,
      ST_FILL,
      ST_RUN
   } state_t;

endpackage

// File: rtl/vdb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module vdb_sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 16
) (
   input  logic             pixel_clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; a flush empties the FIFO but still keeps a word pushed in the same cycle.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= push ? PTR_ONE : '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write, aligned with the pointer behaviour above.
   always_ff @(posedge pixel_clk) begin
      if (flush) begin
         if (push) mem[0] <= wr_data;
      end else if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/vdb_vga_stream_tx.sv
// VGA transmitter: raster counters, frame-alignment FSM and registered pixel/sync outputs.
module vdb_vga_stream_tx
   import vdb_vga_pkg::*;
#(
   parameter int HOR_ACT    = DEF_HOR_ACT,
   parameter int HOR_FP     = DEF_HOR_FP,
   parameter int HOR_SYNC   = DEF_HOR_SYNC,
   parameter int HOR_BP     = DEF_HOR_BP,
   parameter int VERT_ACT   = DEF_VERT_ACT,
   parameter int VERT_FP    = DEF_VERT_FP,
   parameter int VERT_SYNC  = DEF_VERT_SYNC,
   parameter int VERT_BP    = DEF_VERT_BP,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        pixel_clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [23:0] s_data,
   input  logic        s_sof,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start,
   output logic        underflow,
   output logic        sync_err
);

   localparam int H_TOTAL = HOR_ACT + HOR_FP + HOR_SYNC + HOR_BP;
   localparam int V_TOTAL = VERT_ACT + VERT_FP + VERT_SYNC + VERT_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT_END  = HW'(HOR_ACT);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(HOR_ACT + HOR_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(HOR_ACT + HOR_FP + HOR_SYNC);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(VERT_ACT);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(VERT_ACT + VERT_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(VERT_ACT + VERT_FP + VERT_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [HW-1:0]           h_cnt;
   logic [VW-1:0]           v_cnt;
   logic                    active;
   logic                    at_origin;
   logic                    h_sync_zone;
   logic                    v_sync_zone;
   logic                    accept;
   logic                    push;
   logic                    pop;
   logic                    flush;
   logic                    pix_ok;
   logic                    under_det;
   logic                    sync_det;
   logic                    full;
   logic                    empty;
   logic [FIFO_WIDTH-1:0]   head_bits;
   fifo_word_t              head;
   fifo_word_t              in_word;

   assign active      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign at_origin   = (h_cnt == '0) && (v_cnt == '0);
   assign h_sync_zone = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
   assign v_sync_zone = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
   assign accept      = s_valid && s_ready;
   assign head        = fifo_word_t'(head_bits);
   assign in_word     = fifo_word_t'({s_sof, s_data});

   vdb_sync_fifo #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .wr_data   (in_word),
      .pop       (pop),
      .rd_data   (head_bits),
      .full      (full),
      .empty     (empty)
   );

   // Back-pressure: HUNT swallows everything, FILL/RUN accept while there is room.
   always_comb begin
      s_ready = 1'b0;
      case (state)
         ST_HUNT:        s_ready = 1'b1;
         ST_FILL, ST_RUN: s_ready = !full;
         default:        s_ready = 1'b0;
      endcase
   end

   // Next-state, FIFO control and error detection, all decided from the current raster position.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      pix_ok    = 1'b0;
      under_det = 1'b0;
      sync_det  = 1'b0;
      if (!enable) begin
         state_nxt = ST_IDLE;
         flush     = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               flush     = 1'b1;
               state_nxt = ST_HUNT;
            end
            ST_HUNT: begin
               if (accept && s_sof) begin
                  push      = 1'b1;
                  state_nxt = ST_FILL;
               end
            end
            ST_FILL: begin
               push = accept;
               if (at_origin && !empty) begin
                  pop       = 1'b1;
                  pix_ok    = 1'b1;
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               push = accept;
               if (active) begin
                  if (empty) begin
                     under_det = 1'b1;
                  end else if (head.sof && !at_origin) begin
                     pop      = 1'b1;
                     sync_det = 1'b1;
                  end else begin
                     pop    = 1'b1;
                     pix_ok = 1'b1;
                  end
               end
               if (under_det || sync_det) begin
                  flush     = 1'b1;
                  push      = accept && s_sof;
                  state_nxt = (accept && s_sof) ? ST_FILL : ST_HUNT;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM state, raster counters and all registered pins; frame_start marks a streamed pixel (0,0) actually shown.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         r           <= '0;
         g           <= '0;
         b           <= '0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         underflow   <= under_det;
         sync_err    <= sync_det;
         frame_start <= pix_ok && at_origin;
         r           <= pix_ok ? head.rgb.r : '0;
         g           <= pix_ok ? head.rgb.g : '0;
         b           <= pix_ok ? head.rgb.b : '0;
         if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
         end else begin
            hsync <= !h_sync_zone;
            vsync <= !v_sync_zone;
            de    <= active;
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/vdb_vga_stream_tx.md
# vdb_vga_stream_tx

Synthesizable VGA transmitter that turns a valid/ready RGB pixel stream into VESA-style `r`/`g`/`b`/`hsync`/`vsync` on `pixel_clk`. It sits directly upstream of the virtual VGA monitor model on the devboard and drives it. Frame alignment uses a start-of-frame flag, and a small FIFO decouples the producer from raster timing. Underflow and misaligned-frame errors are detected and recovered from automatically.

## Interface
- `HOR_ACT`, 640: active pixels per line
- `HOR_FP`, 16: horizontal front porch (pixels, 1..255)
- `HOR_SYNC`, 96: hsync width (pixels, 1..255)
- `HOR_BP`, 48: horizontal back porch (pixels, 1..255)
- `VERT_ACT`, 480: active lines per frame
- `VERT_FP`, 11: vertical front porch (lines, 1..255)
- `VERT_SYNC`, 2: vsync width (lines, 1..255)
- `VERT_BP`, 31: vertical back porch (lines, 1..255)
- `FIFO_DEPTH`, 16: pixel FIFO entries, power of 2, ≥4

Ports:
- `pixel_clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  run raster; low = idle, flush
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  stream word accepted when `s_valid & s_ready`
- `s_data`  in  24  `{r,g,b}`, 8 bits each
- `s_sof`  in  1  word is pixel (0,0) of a frame
- `r`, `g`, `b`  out  8 each  pixel colour; 0 outside active video
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `de`  out  1  active video
- `frame_start`  out  1  1-cycle pulse coincident with pixel (0,0) on outputs
- `underflow`  out  1  1-cycle pulse: FIFO empty at an active pixel
- `sync_err`  out  1  1-cycle pulse: `s_sof` word popped at a position other than (0,0)

## Operation
- `H_TOTAL = HOR_ACT+HOR_FP+HOR_SYNC+HOR_BP` (800) and `V_TOTAL` (524) are computed the same way. `h_cnt` is `$clog2(H_TOTAL)` bits wide and `v_cnt` is `$clog2(V_TOTAL)` bits wide.
- Line order: active `[0,HOR_ACT)`, then FP, then sync, then BP. The frame uses the same order in lines.
- `hsync`=0 for `h_cnt` in `[HOR_ACT+HOR_FP, HOR_ACT+HOR_FP+HOR_SYNC)`.
- `vsync`=0 for `v_cnt` in the equivalent range. `vsync` changes only when `h_cnt`=0, so it is stable at every hsync rising edge.
- `h_cnt` wraps at `H_TOTAL-1`. `v_cnt` increments on each `h_cnt` wrap and wraps at `V_TOTAL-1`.
- FSM states:
  - IDLE: entered on reset or `enable`=0. Counters are held at 0, the FIFO is flushed, `s_ready`=0.
  - HUNT: `s_ready`=1 and non-SOF words are dropped. An accepted SOF word is pushed → FILL.
  - FILL: `s_ready`=!full. When the counters are at (0,0) and the FIFO is non-empty, pop → RUN. If the FIFO is empty at (0,0), stay in FILL with no error.
  - RUN: `s_ready`=!full. Pop exactly one word per active pixel.
- Errors in RUN, both evaluated at pop time:
  - Empty at an active pixel → `underflow`, flush, HUNT.
  - Popped word has sof at a position other than (0,0) → `sync_err`, flush, HUNT.
  - The offending pixel and the rest of the frame output black. `de`/syncs keep running.
- Simultaneous push and pop: both happen. Pop on full, push on empty: standard FIFO semantics.
- Words arriving in IDLE are not accepted.
- `enable` going 0 mid-frame returns to IDLE on the next edge. When `enable` returns, the raster restarts at (0,0).
- Reset mid-frame behaves the same but is asynchronous.

## Timing
- Reset values: `hsync`=1, `vsync`=1, `de`=0, `r`/`g`/`b`=0, `frame_start`=0, `underflow`=0, `sync_err`=0, `s_ready`=0. State is IDLE and the FIFO is empty.
- All outputs except `s_ready` are registered. There is 1 cycle of latency from counter value to pins. The pop decision and the FIFO read are combinational from the counter and state, registered into `r`/`g`/`b`.
- `s_ready` is combinational from state and the FIFO full flag.
- Minimum latency from SOF accepted to its pixel on the pins: next (0,0) + 1 cycle.
- Frame period: `H_TOTAL*V_TOTAL` cycles (419200 at defaults).

## Structure
- Package `vdb_vga_pkg`: `rgb_t` (packed r,g,b), FSM state enum, and the default VGA timing localparams.
- Sub-module `vdb_sync_fifo`:
  - Parameterised width (25 bits: sof + rgb) and depth.
  - Async active-low reset and a synchronous `flush`.
  - Signals: `full`, `empty`, first-word-fall-through read data.

## Test plan
Small timing (8/2/3/2 × 4/1/1/1, `FIFO_DEPTH`=4) unless stated.
- Reset values: `rst_n`=0 → all outputs at their reset values. Deassert reset with `enable`=1 → `hsync` goes low for 3 cycles starting 10 cycles after the first `de` rise, and the period is 15 cycles.
- Full frame, default 640×480 timing: a producer streams a counter pattern with SOF → the monitor framebuffer matches pixel-for-pixel. `frame_start` pulses every 419200 cycles, with no `underflow` or `sync_err`.
- Underflow: producer stalls at line 2 pixel 5 → `underflow` pulses on that pixel, and `r`/`g`/`b`=0 to the end of the frame. The next SOF resumes clean output at the next (0,0).
- HUNT: 6 non-SOF words then SOF → the first 6 words are dropped (`s_ready`=1 throughout), and the SOF pixel appears with `frame_start`.
- Misplaced SOF: SOF set on pixel (0,3) of the second frame → `sync_err` pulses at (0,3), output is black, and the block resyncs.
- `enable` dropped mid-line 1 for 5 cycles → outputs idle with syncs high, `s_ready`=0. On re-enable, `de` first rises 1 cycle later and the new frame starts at (0,0). An async reset asserted mid-pixel clears outputs immediately.
